// File: rtl/fft_unload.sv
// Unloads 2048 FFT bins from four digit-reversed result banks in natural order.
// Credit-limited read issue keeps the output FIFO from overflowing under backpressure.
module fft_unload #(
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                iCLK,
    input  logic                iRESET,
    input  logic                iSTART,
    input  logic                iSET,
    output logic                oSET_SEL,
    output logic                oRD_EN,
    output logic [1:0]          oBANK_SEL,
    output logic [8:0]          oADDR_RD,
    input  logic [2*DATA_W-1:0] iRD_DATA_0,
    input  logic [2*DATA_W-1:0] iRD_DATA_1,
    input  logic [2*DATA_W-1:0] iRD_DATA_2,
    input  logic [2*DATA_W-1:0] iRD_DATA_3,
    output logic [DATA_W-1:0]   oDATA_RE,
    output logic [DATA_W-1:0]   oDATA_IM,
    output logic [10:0]         oINDEX,
    output logic                oVALID,
    input  logic                iREADY,
    output logic                oSOP,
    output logic                oEOP,
    output logic                oBUSY,
    output logic                oDONE
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = 2 * DATA_W + 11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    state_t state, state_nxt;

    logic [10:0]       k_rd;
    logic [10:0]       k_out;
    logic              last_acc;
    logic [10:0]       r_rd;
    logic              start;
    logic              issue;
    logic              push;
    logic              pop;
    int                outstanding;

    logic [RD_LAT-1:0] p_vld;
    logic [1:0]        p_bank [RD_LAT];
    logic [10:0]       p_k    [RD_LAT];
    logic [2*DATA_W-1:0] rd_word;

    logic [FW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [FW-1:0]     head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Natural bin k -> storage index: reverse the radix-4 digits, radix-2 digit last.
    assign r_rd  = {k_rd[1:0], k_rd[3:2], k_rd[5:4], k_rd[7:6], k_rd[9:8], k_rd[10]};
    assign start = (state == IDLE) && iSTART;
    assign push  = p_vld[RD_LAT-1];
    assign pop   = oVALID && iREADY;

    always_comb begin
        outstanding = int'(cnt) - int'(pop);
        for (int i = 0; i < RD_LAT; i++) begin
            outstanding += int'(p_vld[i]);
        end
        issue = (state == ISSUE) && (outstanding < FIFO_DEPTH);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (iSTART) state_nxt = ISSUE;
            ISSUE:   if (issue && (k_rd == 11'd2047)) state_nxt = DRAIN;
            DRAIN:   if ((cnt == '0) && last_acc) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            k_rd     <= '0;
            k_out    <= '0;
            last_acc <= 1'b0;
            oSET_SEL <= 1'b0;
        end else if (start) begin
            k_rd     <= '0;
            k_out    <= '0;
            last_acc <= 1'b0;
            oSET_SEL <= iSET;
        end else begin
            if (issue && (k_rd != 11'd2047)) k_rd <= k_rd + 11'd1;
            if (pop) begin
                k_out <= k_out + 11'd1;
                if (k_out == 11'd2047) last_acc <= 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oBANK_SEL <= '0;
            oADDR_RD  <= '0;
        end else if (issue) begin
            {oBANK_SEL, oADDR_RD} <= r_rd;
        end
    end

    // Stage 0 of the tag pipe is the read strobe itself.
    assign oRD_EN = p_vld[0];

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            p_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                p_bank[i] <= '0;
                p_k[i]    <= '0;
            end
        end else begin
            p_vld[0]  <= issue;
            p_bank[0] <= r_rd[10:9];
            p_k[0]    <= k_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                p_vld[i]  <= p_vld[i-1];
                p_bank[i] <= p_bank[i-1];
                p_k[i]    <= p_k[i-1];
            end
        end
    end

    always_comb begin
        rd_word = iRD_DATA_0;
        unique case (p_bank[RD_LAT-1])
            2'd0: rd_word = iRD_DATA_0;
            2'd1: rd_word = iRD_DATA_1;
            2'd2: rd_word = iRD_DATA_2;
            2'd3: rd_word = iRD_DATA_3;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {rd_word, p_k[RD_LAT-1]};
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head     = mem[rd_ptr];
    assign oVALID   = (cnt != '0);
    assign oINDEX   = head[10:0];
    assign oDATA_IM = head[11 +: DATA_W];
    assign oDATA_RE = head[FW-1 -: DATA_W];
    assign oSOP     = oVALID && (oINDEX == 11'd0);
    assign oEOP     = oVALID && (oINDEX == 11'd2047);
    assign oBUSY    = (state != IDLE);
    assign oDONE    = (state == FINISH);

endmodule

// File: tb/tb_fft_unload.sv
// Bench for fft_unload: two instances (RD_LAT 2 and 3) against a bin-order model.
// Banks are modelled as functions of storage index; beats must arrive in natural order.
module tb_fft_unload;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int N     = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic set = 1'b0;
    logic ready = 1'b0;

    always #5 clk = ~clk;

    logic [2*DW-1:0] rd_data [2][4];
    logic            set_sel [2];
    logic            rd_en   [2];
    logic [1:0]      bank    [2];
    logic [8:0]      addr    [2];
    logic [DW-1:0]   re      [2];
    logic [DW-1:0]   im      [2];
    logic [10:0]     idx     [2];
    logic            valid   [2];
    logic            sop     [2];
    logic            eop     [2];
    logic            busy    [2];
    logic            done    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fft_unload #(
            .DATA_W(DW),
            .RD_LAT(2 + g),
            .FIFO_DEPTH(DEPTH)
        ) u_dut (
            .iCLK(clk),
            .iRESET(rst_n),
            .iSTART(start),
            .iSET(set),
            .oSET_SEL(set_sel[g]),
            .oRD_EN(rd_en[g]),
            .oBANK_SEL(bank[g]),
            .oADDR_RD(addr[g]),
            .iRD_DATA_0(rd_data[g][0]),
            .iRD_DATA_1(rd_data[g][1]),
            .iRD_DATA_2(rd_data[g][2]),
            .iRD_DATA_3(rd_data[g][3]),
            .oDATA_RE(re[g]),
            .oDATA_IM(im[g]),
            .oINDEX(idx[g]),
            .oVALID(valid[g]),
            .iREADY(ready),
            .oSOP(sop[g]),
            .oEOP(eop[g]),
            .oBUSY(busy[g]),
            .oDONE(done[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    bit chk_zero = 1'b1;
    bit exp_set  = 1'b0;
    logic [15:0] sa = '0;
    logic [15:0] sb = '0;

    bit          running [2];
    int          exp_k   [2];
    int          iss     [2];
    int          first_v [2];
    int          done_cyc[2];
    int          n_done  [2];
    int          last_ac [2];
    bit          stalled [2];
    logic [45:0] sv      [2];
    logic        hv      [2][4];
    logic [8:0]  ha      [2][4];

    function automatic int bitmap(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 5; i++) r = (r << 2) | ((k >> (2 * i)) & 3);
        return (r << 1) | ((k >> 10) & 1);
    endfunction

    function automatic logic [31:0] content(input int r);
        logic [15:0] v;
        v = 16'(r);
        return {v ^ sa, v ^ sb ^ 16'h5a5a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic observe(input int g);
        int k;
        if (!rst_n || chk_zero) begin
            chk("outputs_zero", {set_sel[g], rd_en[g], bank[g], addr[g], re[g], im[g],
                idx[g], valid[g], sop[g], eop[g], busy[g], done[g]}, 64'd0);
            return;
        end
        chk("busy", busy[g], running[g]);
        chk("set_sel", set_sel[g], exp_set);
        if (rd_en[g]) begin
            chk("rd_addr", {bank[g], addr[g]}, bitmap(iss[g]));
            if (iss[g] == 1)    chk("rd_addr_k1", {bank[g], addr[g]}, 11'd512);
            if (iss[g] == 4)    chk("rd_addr_k4", {bank[g], addr[g]}, 11'd128);
            if (iss[g] == 1024) chk("rd_addr_k1024", {bank[g], addr[g]}, 11'd1);
            iss[g]++;
        end
        if (running[g]) chk("credit", (iss[g] - exp_k[g]) <= DEPTH, 1'b1);
        if (stalled[g]) begin
            chk("stall_hold", {valid[g], re[g], im[g], idx[g], sop[g], eop[g]}, sv[g]);
        end
        if (valid[g]) begin
            k = exp_k[g];
            chk("index", idx[g], k);
            chk("data", {re[g], im[g]}, content(bitmap(k)));
            chk("sop", sop[g], k == 0);
            chk("eop", eop[g], k == N - 1);
            if (first_v[g] < 0) first_v[g] = cyc;
        end
        if (done[g]) begin
            n_done[g]++;
            done_cyc[g] = cyc;
            chk("done_beats", exp_k[g], N);
            chk("done_after_last", cyc, last_ac[g] + 2);
            running[g] = 1'b0;
        end
    endtask

    task automatic ram();
        for (int g = 0; g < 2; g++) begin
            for (int i = 3; i > 0; i--) begin
                hv[g][i] = hv[g][i-1];
                ha[g][i] = ha[g][i-1];
            end
            hv[g][0] = rd_en[g];
            ha[g][0] = addr[g];
            for (int b = 0; b < 4; b++) begin
                if (hv[g][1 + g]) rd_data[g][b] = content((b << 9) | int'(ha[g][1 + g]));
                else rd_data[g][b] = $urandom;
            end
        end
    endtask

    task automatic commit();
        for (int g = 0; g < 2; g++) begin
            if (rst_n && start && !running[g]) begin
                running[g]  = 1'b1;
                exp_k[g]    = 0;
                iss[g]      = 0;
                first_v[g]  = -1;
                done_cyc[g] = -1;
                n_done[g]   = 0;
                last_ac[g]  = -10;
                exp_set     = set;
                t0          = cyc + 1;
            end
            if (valid[g] && ready && rst_n) begin
                exp_k[g]++;
                last_ac[g] = cyc;
            end
            stalled[g] = rst_n && valid[g] && !ready;
            sv[g] = {valid[g], re[g], im[g], idx[g], sop[g], eop[g]};
        end
    endtask

    task automatic cycle(input bit rdy, input bit st, input bit s);
        @(negedge clk);
        cyc++;
        for (int g = 0; g < 2; g++) observe(g);
        ram();
        ready = rdy;
        start = st;
        set   = s;
        commit();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            running[g] = 1'b0;
            stalled[g] = 1'b0;
        end
        exp_set = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk_zero = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        chk_zero = 1'b0;
    endtask

    task automatic run(input bit s, input bit bp, input bit inj, input int rst_at, input bit timed);
        int  guard;
        bit  rdy;
        bit  st;
        bit  ss;
        guard = 0;
        cycle(1'b1, 1'b1, s);
        while ((running[0] || running[1]) && guard < 12000) begin
            if (rst_at >= 0 && exp_k[0] == rst_at) begin
                do_reset();
                return;
            end
            rdy = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
            st  = 1'b0;
            ss  = s;
            if (inj && (cyc + 1 == t0 + 10 || cyc + 1 == t0 + 500)) begin
                st = 1'b1;
                ss = ~s;
            end
            cycle(rdy, st, ss);
            guard++;
        end
        chk("run_timeout", guard < 12000, 1'b1);
        repeat (5) cycle(1'b1, 1'b0, s);
        for (int g = 0; g < 2; g++) begin
            chk("done_once", n_done[g], 1);
            if (timed) begin
                chk("first_valid_lat", first_v[g] - t0, 2 + g + 1);
                chk("done_lat", done_cyc[g] - t0, N + 2 + g + 2);
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            running[g] = 1'b0;
            stalled[g] = 1'b0;
            exp_k[g]   = 0;
            iss[g]     = 0;
            n_done[g]  = 0;
            for (int i = 0; i < 4; i++) begin
                hv[g][i] = 1'b0;
                ha[g][i] = '0;
                rd_data[g][i] = '0;
            end
        end
        chk("map_k1", bitmap(1), 512);
        chk("map_k4", bitmap(4), 128);
        chk("map_k1024", bitmap(1024), 1);
        chk("map_k2047", bitmap(2047), 2047);
        chk("map_k3", bitmap(3), 1536);

        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (100) cycle(1'b0, 1'b0, 1'b0);
        chk_zero = 1'b0;

        sa = 16'h0000;
        sb = 16'h0000;
        run(1'b0, 1'b0, 1'b0, -1, 1'b1);

        sa = 16'($urandom);
        sb = 16'($urandom);
        run(1'b1, 1'b1, 1'b1, -1, 1'b0);

        run(1'b1, 1'b0, 1'b0, 700, 1'b0);

        sa = 16'($urandom);
        sb = 16'($urandom);
        run(1'b0, 1'b0, 1'b0, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
